// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative RV32M multiply/divide unit beside the integer EX stage.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int UNROLL     = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       rs1,
  input  logic [XLEN-1:0]       rs2,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  rd_enable_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall_req,
  output logic                  done,
  output logic [XLEN-1:0]       rd_num_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  rd_enable_out
);

  localparam int c_ITER  = XLEN / UNROLL;
  localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;

  localparam logic [2:0] c_OP_MUL    = 3'd0;
  localparam logic [2:0] c_OP_MULH   = 3'd1;
  localparam logic [2:0] c_OP_MULHSU = 3'd2;
  localparam logic [2:0] c_OP_DIV    = 3'd4;
  localparam logic [2:0] c_OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [2:0]            r_op;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic                  r_rd_en;
  logic                  r_neg;
  logic                  r_fast;
  logic [XLEN-1:0]       r_fast_val;
  logic [XLEN-1:0]       r_divisor;
  logic [2*XLEN-1:0]     r_acc;
  logic [2*XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]       r_mplier;
  logic [XLEN-1:0]       r_rem;
  logic [XLEN-1:0]       r_quo;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]       r_result;

  // Operand decode for a new request
  logic            w_accept, w_is_div;
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_res_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div0, w_ovf, w_fast;
  logic [XLEN-1:0] w_fast_val;

  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_is_div   = op[2];
  assign w_a_signed = (op == c_OP_MULH) || (op == c_OP_MULHSU) || (op == c_OP_DIV) || (op == c_OP_REM);
  assign w_b_signed = (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
  assign w_a_neg    = w_a_signed && rs1[XLEN-1];
  assign w_b_neg    = w_b_signed && rs2[XLEN-1];
  assign w_mag_a    = w_a_neg ? (~rs1 + 1'b1) : rs1;
  assign w_mag_b    = w_b_neg ? (~rs2 + 1'b1) : rs2;
  // The remainder follows the dividend; everything else follows the operand XOR
  assign w_res_neg  = (op == c_OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0     = w_is_div && (rs2 == '0);
  assign w_ovf      = ((op == c_OP_DIV) || (op == c_OP_REM)) && (rs1 == c_MIN_NEG) && (rs2 == c_ALL_ONES);
  assign w_fast     = w_div0 || w_ovf;
  always_comb begin
    w_fast_val = '0;
    if (w_div0)
      w_fast_val = op[1] ? rs1 : c_ALL_ONES;
    else if (w_ovf)
      w_fast_val = op[1] ? '0 : rs1;
  end

  // One iteration step: UNROLL multiplier bits and UNROLL quotient bits
  logic [2*XLEN-1:0] w_acc_nxt, w_mcand_nxt;
  logic [XLEN-1:0]   w_mplier_nxt, w_rem_nxt, w_quo_nxt;
  logic [XLEN:0]     w_part;

  always_comb begin
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_part       = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (w_mplier_nxt[0])
        w_acc_nxt = w_acc_nxt + w_mcand_nxt;
      w_mcand_nxt  = w_mcand_nxt << 1;
      w_mplier_nxt = w_mplier_nxt >> 1;

      w_part    = {w_rem_nxt, w_quo_nxt[XLEN-1]};
      w_quo_nxt = w_quo_nxt << 1;
      if (w_part >= {1'b0, r_divisor}) begin
        w_part       = w_part - {1'b0, r_divisor};
        w_quo_nxt[0] = 1'b1;
      end
      w_rem_nxt = w_part[XLEN-1:0];
    end
  end

  // Sign correction and result select, valid while in DONE
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_result;

  assign w_prod    = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix = r_neg ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_neg ? (~r_rem + 1'b1) : r_rem;

  always_comb begin
    w_result = '0;
    if (r_fast) begin
      w_result = r_fast_val;
    end else begin
      case (r_op)
        c_OP_MUL:      w_result = w_prod[XLEN-1:0];
        3'd1, 3'd2, 3'd3: w_result = w_prod[2*XLEN-1:XLEN];
        3'd4, 3'd5:    w_result = w_quo_fix;
        default:       w_result = w_rem_fix;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    busy          = (r_state != S_IDLE);
    stall_req     = w_accept || (r_state == S_RUN);
    done          = (r_state == S_DONE) && !flush;
    rd_enable_out = done && r_rd_en;
    rd_num_out    = done ? w_result : r_result;
    rd_addr_out   = r_rd_addr;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = w_fast ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (flush)
          w_state_nxt = S_IDLE;
        else if (r_cnt == c_CNT_W'(c_ITER - 1))
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_rd_addr  <= '0;
      r_rd_en    <= 1'b0;
      r_neg      <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_val <= '0;
      r_divisor  <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= op;
            r_rd_addr  <= rd_addr_in;
            r_rd_en    <= rd_enable_in;
            r_neg      <= w_res_neg;
            r_fast     <= w_fast;
            r_fast_val <= w_fast_val;
            r_divisor  <= w_mag_b;
            r_acc      <= '0;
            r_mcand    <= {{XLEN{1'b0}}, w_mag_a};
            r_mplier   <= w_mag_b;
            r_rem      <= '0;
            r_quo      <= w_mag_a;
            r_cnt      <= '0;
          end
        end
        S_RUN: begin
          if (!flush) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_cnt    <= r_cnt + c_CNT_W'(1);
          end
        end
        S_DONE: begin
          if (!flush)
            r_result <= w_result;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Self-checking bench for ex_muldiv (vector table, random, corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush, rd_enable_in;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_addr_in;
  logic        busy, stall_req, done, rd_enable_out;
  logic [31:0] rd_num_out;
  logic [4:0]  rd_addr_out;

  logic        u4_start;
  logic [2:0]  u4_op;
  logic [31:0] u4_rs1, u4_rs2;
  logic        u4_busy, u4_stall, u4_done, u4_rd_en_out;
  logic [31:0] u4_num;
  logic [4:0]  u4_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .UNROLL(1), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_addr_in(rd_addr_in), .rd_enable_in(rd_enable_in), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done), .rd_num_out(rd_num_out),
    .rd_addr_out(rd_addr_out), .rd_enable_out(rd_enable_out)
  );

  ex_muldiv #(.XLEN(32), .UNROLL(4), .REG_ADDR_W(5)) u_dut4 (
    .clk(clk), .rst(rst), .start(u4_start), .op(u4_op), .rs1(u4_rs1), .rs2(u4_rs2),
    .rd_addr_in(5'd3), .rd_enable_in(1'b1), .flush(1'b0),
    .busy(u4_busy), .stall_req(u4_stall), .done(u4_done), .rd_num_out(u4_num),
    .rd_addr_out(u4_addr), .rd_enable_out(u4_rd_en_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: widen operands and use plain 64-bit / native signed arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic [31:0] r;
    xa = (o == 3'd1 || o == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (o == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    case (o)
      3'd0:             r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
      default: begin
        if (b == 32'd0)
          r = o[1] ? a : 32'hFFFF_FFFF;
        else if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = o[1] ? 32'd0 : a;
        else if (o == 3'd4) r = 32'($signed(a) / $signed(b));
        else if (o == 3'd5) r = a / b;
        else if (o == 3'd6) r = 32'($signed(a) % $signed(b));
        else                r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 32'd0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue at a negedge, follow to done, check value/latency/stall window/hold
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic en,
                        input logic [31:0] exp, input int exp_lat);
    int lat, stalls;
    lat = 0; stalls = 0;
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd_addr_in = rd; rd_enable_in = en;
    #1;
    if (stall_req) stalls++;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
      @(negedge clk);
      if (done) break;
      if (stall_req) stalls++;
    end
    if (!done) begin
      chk({name, " timeout"}, 64'(lat), 64'(exp_lat));
      return;
    end
    chk({name, " value"}, 64'(rd_num_out), 64'(exp));
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " stall cycles"}, 64'(stalls), 64'(exp_lat));
    chk({name, " done outs"}, {stall_req, rd_enable_out, rd_addr_out}, {1'b0, en, rd});
    @(negedge clk);
    chk({name, " hold"}, {done, busy, rd_num_out}, {2'b00, exp});
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] held, a, b;
    logic [2:0]  o;
    int          cnt;

    vecs[0]  = '{"mul7x-3",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{"mulhu-1-1", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{"mulh-1-1",  3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[3]  = '{"mulhsu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{"div-7/2",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{"rem-7/2",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{"divu100/7", 3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{"remu100/7", 3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{"divu5/0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"rem7/0",    3'd6, 32'd7,          32'd0,         32'd7,         1};
    vecs[10] = '{"div ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"rem ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{"div 7/-2",  3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[13] = '{"mul3x4",    3'd0, 32'd3,          32'd4,         32'd12,        33};

    start = 0; flush = 0; op = 0; rs1 = 0; rs2 = 0; rd_addr_in = 0; rd_enable_in = 0;
    u4_start = 0; u4_op = 0; u4_rs1 = 0; u4_rs2 = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset outs", {busy, stall_req, done, rd_num_out, rd_addr_out, rd_enable_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), i[0], vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = (i % 2 == 0) ? 32'hFFFF_FFFF : $urandom; end
        2: begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(1, 20)) - 32'd10; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      run_op("random", o, a, b, 5'($urandom), 1'($urandom), ref_op(o, a, b), ref_lat(o, a, b));
    end

    // start together with flush in IDLE is dropped
    start = 1; flush = 1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    #1 chk("start+flush stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1 start = 0; flush = 0;
    @(negedge clk);
    chk("start+flush idle", {busy, done}, 2'b00);

    // flush in the tenth RUN cycle
    held = rd_num_out;
    start = 1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rd_enable_in = 1;
    @(posedge clk); #1 start = 0;
    repeat (10) @(negedge clk);
    chk("flush pre busy", 64'(busy), 64'd1);
    flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush busy low", 64'(busy), 64'd0);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (done) cnt++; end
    chk("flush no done", 64'(cnt), 64'd0);
    chk("flush rd_num held", 64'(rd_num_out), 64'(held));
    run_op("mul after flush", 3'd0, 32'd3, 32'd4, 5'd9, 1'b1, 32'd12, 33);

    // flush during the DONE cycle of a fast-path op
    held = rd_num_out;
    start = 1; op = 3'd5; rs1 = 32'd5; rs2 = 32'd0;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    flush = 1;
    #1 chk("flush in DONE", {done, rd_enable_out, rd_num_out}, {2'b00, held});
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush DONE after", {busy, rd_num_out}, {1'b0, held});

    // asynchronous reset mid-RUN
    start = 1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd5; rd_addr_in = 5'd7; rd_enable_in = 1;
    @(posedge clk); #1 start = 0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst mid-run", {busy, stall_req, done, rd_num_out, rd_addr_out, rd_enable_out}, 64'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (40) begin @(negedge clk); if (done) cnt++; end
    chk("rst no done", 64'(cnt), 64'd0);

    // UNROLL=4 build: MUL 3x4 in ITER+1 = 9 cycles
    u4_start = 1; u4_op = 3'd0; u4_rs1 = 32'd3; u4_rs2 = 32'd4;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk); cnt++;
      #1 u4_start = 0;
      @(negedge clk);
      if (u4_done) break;
    end
    chk("unroll4 latency", 64'(cnt), 64'd9);
    chk("unroll4 value", {u4_done, u4_rd_en_out, u4_addr, u4_num}, {2'b11, 5'd3, 32'd12});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle execute unit for the RV32M (and XLEN-generic) multiply/divide ops.
- Sits beside the single-cycle integer EX stage and receives the same operand, rd-address and rd-enable fields.
- Holds the pipeline via stall_req while iterating, then presents one writeback result.
- Iterative shift-add multiply and restoring divide, at UNROLL bits per cycle.

Parameters:
- XLEN, 32, operand/result width; must be ≥8 and a multiple of UNROLL.
- UNROLL, 1, bits retired per iteration cycle; ITER = XLEN/UNROLL.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- start  in  1  op request, valid for one cycle.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B.
- rd_addr_in  in  REG_ADDR_W  destination register.
- rd_enable_in  in  1  writeback request.
- flush  in  1  abort the in-flight op (branch mispredict).
- busy  out  1  state != IDLE.
- stall_req  out  1  freeze upstream stages.
- done  out  1  result valid pulse.
- rd_num_out  out  XLEN  result.
- rd_addr_out  out  REG_ADDR_W  latched rd.
- rd_enable_out  out  1  equals done & latched rd_enable_in.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: all registered outputs 0; state IDLE; rd_num_out = 0; rd_addr_out = 0.
  - rst mid-op: discards the op, no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start & !flush: latch op, rs1, rs2, rd_addr_in and rd_enable_in.
  - Compute operand magnitudes and the result sign:
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both operands signed.
  - Clear the iteration counter.
  - Next state:
    - RUN normally.
    - DONE directly when the fast path applies (below).
- Fast path (next state DONE, latency 1):
  - Divide ops with rs2 == 0:
    - DIV/DIVU give all-ones.
    - REM/REMU give rs1.
  - DIV/REM with rs1 = 1<<(XLEN-1) and rs2 = all-ones:
    - DIV gives rs1.
    - REM gives 0.
- RUN:
  - Each cycle retires UNROLL bits.
  - Multiply: 2·XLEN-bit unsigned shift-add product on the magnitudes.
  - Divide: restoring shift-subtract on the magnitudes, producing quotient and remainder.
  - Counter reaches ITER-1 → DONE.
- DONE (one cycle):
  - Apply sign correction and select the result:
    - MUL: product low half.
    - MULH/MULHSU/MULHU: product high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder, which takes the sign of the dividend.
  - Register the result to rd_num_out, which holds until the next done.
  - done = 1; next state IDLE.
- Latency:
  - Normal path: start edge to done = ITER+1 cycles.
  - Fast path: 1 cycle.
- Back-to-back: start is accepted only in IDLE. start in RUN/DONE is ignored; the issuing stage is stalled, so it cannot occur legally.
- stall_req (combinational) = (state==IDLE & start & !flush) | state==RUN. Low in DONE, so the consumer advances on the done cycle.
- flush:
  - In RUN or DONE: next state IDLE, done suppressed, rd_num_out unchanged.
  - Together with start in IDLE: start is ignored.
- Width rule: all arithmetic is unsigned on XLEN/2·XLEN vectors. Signs are applied by two's-complement negation at DONE.

Test Plan:
- MUL 7 × 0xFFFFFFFD (XLEN 32, UNROLL 1) → done exactly 33 cycles after start, rd_num_out = 0xFFFFFFEB, stall_req high cycles 0–32.
- MULHU and MULH with 0xFFFFFFFF × 0xFFFFFFFF → MULHU 0xFFFFFFFE. MULH 0x00000000 (−1 × −1 = 1).
- MULHSU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV/REM of 0xFFFFFFF9 (−7) by 2 → DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU 100/7 → 14, REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 7/0 → 7, both done 1 cycle after start.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, done 1 cycle after start; REM of the same operands → 0.
- Aborts and UNROLL scaling:
  - flush at RUN cycle 10 → no done, busy low next cycle; a following MUL 3×4 → 12.
  - rst asserted mid-RUN → all outputs 0 immediately.
  - UNROLL=4 build: MUL 3×4 → done after 9 cycles.
